bert_pattern_gen: RTL and testbench

- Transmit-side pattern source for the bit error ratio tester.
- Produces the 13-bit words that the receive-side comparator checks against its reference copy.
- Generates PRBS-13, fixed or alternating words over a valid/ready handshake.
- Supports deterministic single-bit error injection so the comparator's error totals can be checked end to end.
- Keeps saturating transfer and injection counters.

---
 rtl/bert_pkg.sv | 55 +++++
 rtl/bert_pattern_gen_if.sv | 14 +
 rtl/bert_lfsr13.sv | 43 ++++
 rtl/bert_pattern_gen.sv | 152 +++++++++++++++
 tb/tb_bert_pattern_gen.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bert_pkg.sv
// Shared definitions for the BERT transmit pattern source: word width, LFSR
// taps, fixed pattern constants, mode and state encodings, and the pure
// helper functions used by both the LFSR and the top-level word selection.
package bert_pkg;

  localparam int WIDTH = 13;
  typedef logic [WIDTH-1:0] word_t;

  // PRBS-13 taps 13,4,3,1 expressed as zero-based state bit indices.
  localparam int TAP_A = 12;
  localparam int TAP_B = 3;
  localparam int TAP_C = 2;
  localparam int TAP_D = 0;

  localparam word_t LOCKUP_SEED = 13'h0001;
  localparam word_t ALT_A       = 13'h0AAA;
  localparam word_t ALT_B       = 13'h1555;

  // Highest legal bit index for error injection.
  localparam logic [3:0] MAX_POS = 4'(WIDTH - 1);

  typedef enum logic [1:0] {
    MODE_PRBS  = 2'd0,
    MODE_FIXED = 2'd1,
    MODE_ALT   = 2'd2,
    MODE_ZERO  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // One Fibonacci step: feedback shifts in at bit 0.
  function automatic word_t lfsr_step(word_t s);
    return {s[WIDTH-2:0], s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D]};
  endfunction

  // An all-zero LFSR never leaves zero, so a zero seed is replaced.
  function automatic word_t seed_fix(word_t s);
    return (s == '0) ? LOCKUP_SEED : s;
  endfunction

  function automatic word_t pattern_word(mode_e m, word_t fixed, word_t prbs,
                                         logic phase);
    case (m)
      MODE_PRBS:  return prbs;
      MODE_FIXED: return fixed;
      MODE_ALT:   return phase ? ALT_B : ALT_A;
      default:    return '0;
    endcase
  endfunction

endpackage

// File: rtl/bert_pattern_gen_if.sv
// Valid/ready word stream between the pattern source and its sink.
//   tx_data  : 13-bit pattern word
//   tx_valid : tx_data is valid
//   tx_ready : sink accepts; a transfer is tx_valid & tx_ready
interface bert_pattern_gen_if;
  import bert_pkg::*;

  word_t tx_data;
  logic  tx_valid;
  logic  tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/bert_lfsr13.sv
// PRBS-13 state register with seed load and period-wrap detection.
//   load/load_val : load a new seed (zero replaced by 13'h0001); it also
//                   becomes the start seed that wrap is measured against
//   advance       : step the LFSR once
//   state         : current LFSR value
//   wrap          : one-cycle pulse after an advance lands on the start seed
module bert_lfsr13
  import bert_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  word_t load_val,
  input  logic  advance,
  output word_t state,
  output logic  wrap
);

  word_t start_q;
  word_t next_s;

  assign next_s = lfsr_step(state);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= LOCKUP_SEED;
      start_q <= LOCKUP_SEED;
      wrap    <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (load) begin
        state   <= seed_fix(load_val);
        start_q <= seed_fix(load_val);
      end else if (advance) begin
        state <= next_s;
        wrap  <= (next_s == start_q);
      end
    end
  end

endmodule

// File: rtl/bert_pattern_gen.sv
// Transmit-side BERT pattern source. Emits PRBS-13, fixed, alternating or
// all-zero words over a valid/ready stream, with single-bit error injection
// and saturating transfer/injection counters.
//   clk, rst        : clock, asynchronous active-high reset
//   enable          : level request to generate words
//   mode            : pattern select, latched on IDLE->RUN
//   seed, seed_load : LFSR seed and load pulse (IDLE only)
//   fixed_pattern   : word for fixed mode, latched on IDLE->RUN
//   inject_req/pos  : request a flip of bit inject_pos (0..12) on the next load
//   tx              : word stream (master side)
//   inject_ack      : pulse when a flipped word is loaded into tx_data
//   period_wrap     : pulse when the PRBS state returns to its start seed
//   word_count      : accepted transfers, saturating
//   injected_count  : accepted flipped words, saturating
module bert_pattern_gen
  import bert_pkg::*;
#(
  parameter int WIDTH = 13,
  parameter int CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [1:0]             mode,
  input  logic [WIDTH-1:0]       seed,
  input  logic                   seed_load,
  input  logic [WIDTH-1:0]       fixed_pattern,
  input  logic                   inject_req,
  input  logic [3:0]             inject_pos,
  bert_pattern_gen_if.master     tx,
  output logic                   inject_ack,
  output logic                   period_wrap,
  output logic [CNT_W-1:0]       word_count,
  output logic [CNT_W-1:0]       injected_count
);

  state_e     state_q, state_d;
  mode_e      mode_q;
  word_t      fixed_q;
  word_t      data_q;
  word_t      lfsr_state;
  word_t      first_word, next_word, load_word, flip_mask;
  logic       alt_phase_q;
  logic       pending_q;
  logic [3:0] pos_q;
  logic       flipped_q;
  logic       load_first, load_next, load;
  logic       transfer, advance, lfsr_load, inj_ok;

  assign transfer  = tx.tx_valid & tx.tx_ready;
  assign tx.tx_data = data_q;
  assign load      = load_first | load_next;
  assign advance   = transfer & (mode_q == MODE_PRBS);
  assign lfsr_load = (state_q == ST_IDLE) & seed_load;
  assign inj_ok    = inject_req & (inject_pos <= MAX_POS);
  assign flip_mask = pending_q ? (word_t'(1) << pos_q) : '0;

  // A seed loaded on the same edge as the first word is used directly.
  assign first_word = pattern_word(mode_e'(mode), fixed_pattern,
                                   seed_load ? seed_fix(seed) : lfsr_state,
                                   alt_phase_q);
  assign next_word  = pattern_word(mode_q, fixed_q, lfsr_step(lfsr_state),
                                   ~alt_phase_q);
  assign load_word  = load_first ? first_word : next_word;

  bert_lfsr13 u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (lfsr_load),
    .load_val (seed),
    .advance  (advance),
    .state    (lfsr_state),
    .wrap     (period_wrap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    load_first  = 1'b0;
    load_next   = 1'b0;
    tx.tx_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d    = ST_RUN;
          load_first = 1'b1;
        end
      end
      ST_RUN: begin
        tx.tx_valid = 1'b1;
        if (transfer) begin
          if (enable) load_next = 1'b1;
          else        state_d   = ST_DRAIN;
        end
      end
      ST_DRAIN: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q         <= MODE_PRBS;
      fixed_q        <= '0;
      data_q         <= '0;
      alt_phase_q    <= 1'b0;
      pending_q      <= 1'b0;
      pos_q          <= '0;
      flipped_q      <= 1'b0;
      inject_ack     <= 1'b0;
      word_count     <= '0;
      injected_count <= '0;
    end else begin
      inject_ack <= 1'b0;

      if (load_first) begin
        mode_q  <= mode_e'(mode);
        fixed_q <= fixed_pattern;
      end

      if (transfer && mode_q == MODE_ALT) alt_phase_q <= ~alt_phase_q;

      // The flip uses the pending flag as it stood before this edge, so a
      // request arriving with a load lands on the following word.
      if (load) begin
        data_q     <= load_word ^ flip_mask;
        flipped_q  <= pending_q;
        inject_ack <= pending_q;
      end

      if (inj_ok) begin
        pending_q <= 1'b1;
        pos_q     <= inject_pos;
      end else if (load) begin
        pending_q <= 1'b0;
      end

      if (transfer) begin
        if (word_count != '1) word_count <= word_count + 1'b1;
        if (flipped_q && injected_count != '1)
          injected_count <= injected_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bert_pattern_gen.sv
// Directed bench for bert_pattern_gen: PRBS start-up, back-pressure,
// injection, alternating/fixed modes, full-period wrap and mid-run reset.
module tb_bert_pattern_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [12:0] seed = '0;
  logic        seed_load = 1'b0;
  logic [12:0] fixed_pattern = '0;
  logic        inject_req = 1'b0;
  logic [3:0]  inject_pos = '0;
  logic        inject_ack;
  logic        period_wrap;
  logic [31:0] word_count;
  logic [31:0] injected_count;

  int checks = 0;
  int errors = 0;

  bert_pattern_gen_if tx_if ();

  bert_pattern_gen #(.WIDTH(13), .CNT_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .mode           (mode),
    .seed           (seed),
    .seed_load      (seed_load),
    .fixed_pattern  (fixed_pattern),
    .inject_req     (inject_req),
    .inject_pos     (inject_pos),
    .tx             (tx_if),
    .inject_ack     (inject_ack),
    .period_wrap    (period_wrap),
    .word_count     (word_count),
    .injected_count (injected_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [12:0] prbs_next(input logic [12:0] s);
    logic fb;
    fb = s[12] ^ s[3] ^ s[2] ^ s[0];
    return {s[11:0], fb};
  endfunction

  logic [12:0] exp;
  int          wc;
  int          bad;
  int          acks;
  int          wraps;
  int          wrap_at;

  initial begin
    tx_if.tx_ready = 1'b0;

    // Reset state
    #1;
    check("rst_valid", 32'(tx_if.tx_valid), 0);
    check("rst_data", 32'(tx_if.tx_data), 0);
    check("rst_ack", 32'(inject_ack), 0);
    check("rst_wrap", 32'(period_wrap), 0);
    check("rst_wc", word_count, 0);
    check("rst_ic", injected_count, 0);
    tick();
    tick();
    rst = 1'b0;

    // PRBS start-up from seed 0001
    seed = 13'h0001;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    mode = 2'd0;
    enable = 1'b1;
    tx_if.tx_ready = 1'b1;
    check("valid_before_enable_edge", 32'(tx_if.tx_valid), 0);
    tick();
    check("valid_latency", 32'(tx_if.tx_valid), 1);
    check("prbs_w0", 32'(tx_if.tx_data), 32'h0001);
    tick();
    check("prbs_w1", 32'(tx_if.tx_data), 32'h0003);
    tick();
    check("prbs_w2", 32'(tx_if.tx_data), 32'h0007);
    tick();
    check("prbs_w3", 32'(tx_if.tx_data), 32'h000E);
    tick();
    wc = 4;
    check("wc_after_4", word_count, 32'(wc));
    check("prbs_w4", 32'(tx_if.tx_data), 32'h001C);
    exp = 13'h001C;

    // Back-pressure holds data and count
    tx_if.tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_data", 32'(tx_if.tx_data), 32'h001C);
      check("bp_hold_valid", 32'(tx_if.tx_valid), 1);
    end
    check("bp_wc", word_count, 32'(wc));
    tx_if.tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("bp_resume", 32'(tx_if.tx_data), 32'(exp));
      tick();
      exp = prbs_next(exp);
      wc++;
    end
    check("bp_resume_wc", word_count, 32'(wc));

    // Injection at bit 3, requested on a load cycle
    inject_pos = 4'd3;
    inject_req = 1'b1;
    tick();
    wc++;
    exp = prbs_next(exp);
    inject_req = 1'b0;
    check("inj_same_cycle_word", 32'(tx_if.tx_data), 32'(exp));
    check("inj_same_cycle_ack", 32'(inject_ack), 0);
    tick();
    wc++;
    exp = prbs_next(exp);
    check("inj_flipped_word", 32'(tx_if.tx_data), 32'(exp ^ 13'h0008));
    check("inj_ack", 32'(inject_ack), 1);
    check("inj_ic_before", injected_count, 0);
    tick();
    wc++;
    exp = prbs_next(exp);
    check("inj_after_word", 32'(tx_if.tx_data), 32'(exp));
    check("inj_after_ack", 32'(inject_ack), 0);
    check("inj_ic", injected_count, 1);

    // Out-of-range position is dropped
    inject_pos = 4'd13;
    inject_req = 1'b1;
    tick();
    wc++;
    exp = prbs_next(exp);
    inject_req = 1'b0;
    bad = 0;
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      if (tx_if.tx_data !== exp) bad++;
      if (inject_ack) acks++;
      tick();
      wc++;
      exp = prbs_next(exp);
    end
    check("pos13_words", 32'(bad), 0);
    check("pos13_acks", 32'(acks), 0);
    check("pos13_ic", injected_count, 1);
    check("pos13_wc", word_count, 32'(wc));

    // Drain to IDLE
    enable = 1'b0;
    tick();
    wc++;
    exp = prbs_next(exp);
    check("drain_valid", 32'(tx_if.tx_valid), 0);
    tick();
    check("idle_valid", 32'(tx_if.tx_valid), 0);

    // Alternating mode; mode change in RUN ignored
    mode = 2'd2;
    enable = 1'b1;
    tick();
    check("alt_w0", 32'(tx_if.tx_data), 32'h0AAA);
    mode = 2'd1;
    tick();
    wc++;
    check("alt_w1", 32'(tx_if.tx_data), 32'h1555);
    tick();
    wc++;
    check("alt_w2", 32'(tx_if.tx_data), 32'h0AAA);
    tick();
    wc++;
    check("alt_w3", 32'(tx_if.tx_data), 32'h1555);
    enable = 1'b0;
    tick();
    wc++;
    tick();

    // Fixed mode; later input changes ignored
    mode = 2'd1;
    fixed_pattern = 13'h1234;
    enable = 1'b1;
    tick();
    check("fixed_w0", 32'(tx_if.tx_data), 32'h1234);
    fixed_pattern = 13'h0000;
    mode = 2'd2;
    tick();
    wc++;
    check("fixed_w1", 32'(tx_if.tx_data), 32'h1234);
    tick();
    wc++;
    check("fixed_w2", 32'(tx_if.tx_data), 32'h1234);
    enable = 1'b0;
    tick();
    wc++;
    tick();
    check("modes_wc", word_count, 32'(wc));

    // PRBS continues where it left off
    mode = 2'd0;
    enable = 1'b1;
    tick();
    check("prbs_continue", 32'(tx_if.tx_data), 32'(exp));
    enable = 1'b0;
    tick();
    wc++;
    tick();

    // Zero seed -> 0001, full period, single wrap on transfer 8191
    seed = 13'h0000;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    enable = 1'b1;
    tick();
    check("wrap_first_word", 32'(tx_if.tx_data), 32'h0001);
    exp = 13'h0001;
    bad = 0;
    wraps = 0;
    wrap_at = 0;
    for (int n = 1; n <= 8191; n++) begin
      if (tx_if.tx_data !== exp) bad++;
      tick();
      wc++;
      exp = prbs_next(exp);
      if (period_wrap) begin
        wraps++;
        wrap_at = n;
      end
    end
    check("wrap_words", 32'(bad), 0);
    check("wrap_count", 32'(wraps), 1);
    check("wrap_at", 32'(wrap_at), 8191);
    check("wrap_back_to_seed", 32'(tx_if.tx_data), 32'h0001);
    check("wrap_wc", word_count, 32'(wc));

    // Mid-run reset with an injection pending
    inject_pos = 4'd5;
    inject_req = 1'b1;
    tick();
    inject_req = 1'b0;
    tx_if.tx_ready = 1'b0;
    check("pre_rst_valid", 32'(tx_if.tx_valid), 1);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(tx_if.tx_valid), 0);
    check("async_rst_data", 32'(tx_if.tx_data), 0);
    check("async_rst_wc", word_count, 0);
    check("async_rst_ic", injected_count, 0);
    check("async_rst_ack", 32'(inject_ack), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tx_if.tx_ready = 1'b1;
    tick();
    check("post_rst_w0", 32'(tx_if.tx_data), 32'h0001);
    check("post_rst_ack0", 32'(inject_ack), 0);
    tick();
    check("post_rst_w1", 32'(tx_if.tx_data), 32'h0003);
    check("post_rst_ack1", 32'(inject_ack), 0);
    check("post_rst_wc", word_count, 1);
    check("post_rst_ic", injected_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
